// File: rtl/stream_crypt_pkg.sv
// rtl/stream_crypt_pkg.sv - shared constants for the LFSR stream cipher
package stream_crypt_pkg;

  localparam int          BEAT_CNT_W   = 16;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_step_n.sv
// rtl/lfsr_step_n.sv - combinational Fibonacci LFSR advanced STEPS shifts at once
module lfsr_step_n
  import stream_crypt_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter int                STEPS  = 8
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] walk;

  always_comb begin
    walk = state_i;
    for (int i = 0; i < STEPS; i++) begin
      walk = {walk[LFSR_W-2:0], ^(walk & TAPS)};
    end
    state_o = walk;
  end

endmodule

// File: rtl/lfsr_stream_crypt.sv
// rtl/lfsr_stream_crypt.sv - LFSR keystream XOR cipher, 1-cycle registered stream; STREAM_ZERO_GUARD_EN rejects zero seeds
module lfsr_stream_crypt
  import stream_crypt_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter int                LFSR_W         = 16,
  parameter logic [LFSR_W-1:0] TAPS           = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED           = LFSR_W'(DEFAULT_SEED),
  parameter int                REKEY_INTERVAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [BEAT_CNT_W-1:0] beat_cnt,
  output logic                  seed_err
);

  localparam logic [BEAT_CNT_W-1:0] REKEY_LAST = BEAT_CNT_W'(REKEY_INTERVAL - 1);

  logic [LFSR_W-1:0]     state_q, state_d, key_q, key_d, stepped, load_key;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d, seed_err_q, seed_err_d;
  logic                  accept, drain, resync, zero_hit;

  lfsr_step_n #(.LFSR_W(LFSR_W), .TAPS(TAPS), .STEPS(DATA_W)) u_step (
    .state_i (state_q),
    .state_o (stepped)
  );

`ifdef STREAM_ZERO_GUARD_EN
  assign zero_hit = (seed_in == '0);
  assign load_key = zero_hit ? SEED : seed_in;
`else
  assign zero_hit = 1'b0;
  assign load_key = seed_in;
`endif

  assign s_ready = (!m_valid_q || m_ready) && !seed_load;
  assign accept  = s_valid && s_ready;
  assign drain   = m_valid_q && m_ready;
  assign resync  = s_last || ((REKEY_INTERVAL != 0) && (cnt_q == REKEY_LAST));

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    seed_err_d = 1'b0;
    // A key load blocks accepts but lets an in-flight output beat complete.
    if (seed_load) begin
      key_d      = load_key;
      state_d    = load_key;
      cnt_d      = '0;
      seed_err_d = zero_hit;
      if (drain) m_valid_d = 1'b0;
    end else if (accept) begin
      m_data_d  = s_data ^ state_q[DATA_W-1:0];
      m_last_d  = s_last;
      m_valid_d = 1'b1;
      state_d   = resync ? key_q : stepped;
      cnt_d     = resync ? '0 : cnt_q + BEAT_CNT_W'(1);
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEED;
      key_q      <= SEED;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign beat_cnt = cnt_q;
  assign seed_err = seed_err_q;

endmodule
